// File: rtl/matrix_mac_engine.sv
// Signed integer matrix multiplier C = A*B (+ C_prev), M parallel MAC lanes (one per row of C),
// strobe/ack capture of A and B, strobe/ack hand-off of C, wrap or saturate, sticky overflow.
module matrix_mac_engine #(
   parameter int unsigned M          = 4,
   parameter int unsigned P          = 4,
   parameter int unsigned N          = 4,
   parameter int unsigned WORD_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [0:M*P*WORD_WIDTH-1]     matrix_A,
   input  logic [0:P*N*WORD_WIDTH-1]     matrix_B,
   input  logic                          a_stb,
   input  logic                          b_stb,
   input  logic                          acc_en,
   input  logic                          sat_en,
   input  logic                          c_ack,
   output logic                          a_ack,
   output logic                          b_ack,
   output logic [0:M*N*WORD_WIDTH-1]     matrix_C,
   output logic                          c_stb,
   output logic                          ovf,
   output logic                          busy
);

   localparam int unsigned W  = WORD_WIDTH;
   // Wide enough that P full products plus an old C element can never wrap.
   localparam int unsigned AW = 2 * W + $clog2(P) + 1;
   localparam int unsigned KW = (P > 1) ? $clog2(P) : 1;
   localparam int unsigned JW = (N > 1) ? $clog2(N) : 1;

   localparam logic signed [AW-1:0] S_MAX = {{(AW - W + 1){1'b0}}, {(W - 1){1'b1}}};
   localparam logic signed [AW-1:0] S_MIN = {{(AW - W + 1){1'b1}}, {(W - 1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StCalc, StStore, StDone} state_t;

   state_t                   state;
   logic [0:M*P*W-1]         a_reg;
   logic [0:P*N*W-1]         b_reg;
   logic                     acc_mode;
   logic                     sat_mode;
   logic [KW-1:0]            k;
   logic [JW-1:0]            j;
   logic signed [AW-1:0]     acc      [M];

   logic signed [W-1:0]      b_e;
   logic signed [W-1:0]      a_e      [M];
   logic signed [2*W-1:0]    prod     [M];
   logic signed [AW-1:0]     acc_next [M];
   logic signed [W-1:0]      c_old    [M];
   logic signed [AW-1:0]     sum      [M];
   logic [W-1:0]             store_val[M];
   logic [M-1:0]             lane_ovf;

   // Lane datapath: MAC step for step k of column j, and the store value for column j.
   always_comb begin
      b_e = b_reg[(int'(k) * N + int'(j)) * W +: W];
      lane_ovf = '0;
      for (int i = 0; i < M; i++) begin
         a_e[i]      = a_reg[(i * P + int'(k)) * W +: W];
         prod[i]     = a_e[i] * b_e;
         acc_next[i] = acc[i] + {{(AW - 2 * W){prod[i][2*W-1]}}, prod[i]};
         c_old[i]    = matrix_C[(i * N + int'(j)) * W +: W];
         sum[i]      = acc[i];
         if (acc_mode) begin
            sum[i] = acc[i] + {{(AW - W){c_old[i][W-1]}}, c_old[i]};
         end
         lane_ovf[i]  = (sum[i] > S_MAX) || (sum[i] < S_MIN);
         store_val[i] = sum[i][W-1:0];
         if (sat_mode && (sum[i] > S_MAX)) begin
            store_val[i] = S_MAX[W-1:0];
         end else if (sat_mode && (sum[i] < S_MIN)) begin
            store_val[i] = S_MIN[W-1:0];
         end
      end
   end

   // Control FSM with registered handshake/status outputs and the C result register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= StIdle;
         a_ack    <= 1'b0;
         b_ack    <= 1'b0;
         c_stb    <= 1'b0;
         ovf      <= 1'b0;
         busy     <= 1'b0;
         matrix_C <= '0;
         a_reg    <= '0;
         b_reg    <= '0;
         acc_mode <= 1'b0;
         sat_mode <= 1'b0;
         k        <= '0;
         j        <= '0;
         for (int i = 0; i < M; i++) begin
            acc[i] <= '0;
         end
      end else begin
         a_ack <= 1'b0;
         b_ack <= 1'b0;
         unique case (state)
            StIdle: begin
               if (a_stb && b_stb) begin
                  a_reg    <= matrix_A;
                  b_reg    <= matrix_B;
                  acc_mode <= acc_en;
                  sat_mode <= sat_en;
                  ovf      <= 1'b0;
                  k        <= '0;
                  j        <= '0;
                  for (int i = 0; i < M; i++) begin
                     acc[i] <= '0;
                  end
                  a_ack    <= 1'b1;
                  b_ack    <= 1'b1;
                  busy     <= 1'b1;
                  state    <= StCalc;
               end
            end
            StCalc: begin
               for (int i = 0; i < M; i++) begin
                  acc[i] <= acc_next[i];
               end
               if (k == KW'(P - 1)) begin
                  state <= StStore;
               end else begin
                  k <= k + 1'b1;
               end
            end
            StStore: begin
               for (int i = 0; i < M; i++) begin
                  matrix_C[(i * N + int'(j)) * W +: W] <= store_val[i];
                  acc[i] <= '0;
               end
               if (|lane_ovf) begin
                  ovf <= 1'b1;
               end
               k <= '0;
               if (j == JW'(N - 1)) begin
                  c_stb <= 1'b1;
                  state <= StDone;
               end else begin
                  j     <= j + 1'b1;
                  state <= StCalc;
               end
            end
            StDone: begin
               if (c_ack) begin
                  c_stb <= 1'b0;
                  busy  <= 1'b0;
                  j     <= '0;
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Bench for matrix_mac_engine: a 4x4x4 and a 2x3x4 instance, both 8-bit words, checked against
// a plain-arithmetic model of C = A*B (+ C_prev) with wrap/saturate and overflow.
module tb_matrix_mac_engine;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Instance 0: M=4, P=4, N=4
   logic [0:127] a1, b1, c1;
   logic as1 = 0, bs1 = 0, acc1 = 0, sat1 = 0, cack1 = 0;
   logic aack1, back1, cstb1, ovf1, busy1;
   // Instance 1: M=2, P=3, N=4
   logic [0:47]  a2;
   logic [0:95]  b2;
   logic [0:63]  c2;
   logic as2 = 0, bs2 = 0, acc2 = 0, sat2 = 0, cack2 = 0;
   logic aack2, back2, cstb2, ovf2, busy2;

   matrix_mac_engine #(.M(4), .P(4), .N(4), .WORD_WIDTH(W)) u_dut0 (
      .clk(clk), .rst(rst), .matrix_A(a1), .matrix_B(b1), .a_stb(as1), .b_stb(bs1),
      .acc_en(acc1), .sat_en(sat1), .c_ack(cack1), .a_ack(aack1), .b_ack(back1),
      .matrix_C(c1), .c_stb(cstb1), .ovf(ovf1), .busy(busy1)
   );

   matrix_mac_engine #(.M(2), .P(3), .N(4), .WORD_WIDTH(W)) u_dut1 (
      .clk(clk), .rst(rst), .matrix_A(a2), .matrix_B(b2), .a_stb(as2), .b_stb(bs2),
      .acc_en(acc2), .sat_en(sat2), .c_ack(cack2), .a_ack(aack2), .b_ack(back2),
      .matrix_C(c2), .c_stb(cstb2), .ovf(ovf2), .busy(busy2)
   );

   int n_cmp = 0;
   int n_bad = 0;

   int A [4][4];
   int B [4][4];
   int mc [2][4][4];
   logic [0:127] exp_c1;
   logic [0:63]  exp_c2;
   logic exp_ovf1 = 0, exp_ovf2 = 0;
   bit   chk1 = 0, chk2 = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Model: expected C and overflow for instance inst from A, B and its own previous C.
   task automatic run_model(input int inst, input int m, input int p, input int n,
                            input bit acc, input bit sat);
      logic [0:127] ebuf;
      bit ov;
      longint s, v;
      ebuf = '0;
      ov   = 0;
      for (int r = 0; r < m; r++) begin
         for (int c = 0; c < n; c++) begin
            s = acc ? longint'(mc[inst][r][c]) : 0;
            for (int t = 0; t < p; t++) s += longint'(A[r][t]) * longint'(B[t][c]);
            if (s > 127 || s < -128) ov = 1;
            if (sat) v = (s > 127) ? 127 : ((s < -128) ? -128 : s);
            else begin
               v = s & 255;
               if (v > 127) v -= 256;
            end
            mc[inst][r][c] = int'(v);
            ebuf[(r * n + c) * 8 +: 8] = 8'(v);
         end
      end
      if (inst == 0) begin
         exp_c1 = ebuf;
         exp_ovf1 = ov;
      end else begin
         exp_c2 = ebuf[0:63];
         exp_ovf2 = ov;
      end
   endtask

   task automatic set_in(input int inst, input bit as, input bit bs, input bit acc, input bit sat,
                         input bit cack);
      if (inst == 0) begin
         as1 = as; bs1 = bs; acc1 = acc; sat1 = sat; cack1 = cack;
      end else begin
         as2 = as; bs2 = bs; acc2 = acc; sat2 = sat; cack2 = cack;
      end
   endtask

   function automatic bit o_cstb(input int inst); return inst == 0 ? cstb1 : cstb2; endfunction
   function automatic bit o_aack(input int inst); return inst == 0 ? aack1 : aack2; endfunction
   function automatic bit o_back(input int inst); return inst == 0 ? back1 : back2; endfunction
   function automatic bit o_busy(input int inst); return inst == 0 ? busy1 : busy2; endfunction

   task automatic load_ab(input int inst);
      logic [0:127] pa, pb;
      int m, p;
      m  = (inst == 0) ? 4 : 2;
      p  = (inst == 0) ? 4 : 3;
      pa = '0;
      pb = '0;
      for (int r = 0; r < m; r++)
         for (int c = 0; c < p; c++) pa[(r * p + c) * 8 +: 8] = 8'(A[r][c]);
      for (int r = 0; r < p; r++)
         for (int c = 0; c < 4; c++) pb[(r * 4 + c) * 8 +: 8] = 8'(B[r][c]);
      if (inst == 0) begin
         a1 = pa; b1 = pb;
      end else begin
         a2 = pa[0:47]; b2 = pb[0:95];
      end
   endtask

   // One full transaction: capture, latency measurement, hold in DONE, then c_ack.
   task automatic txn(input int inst, input bit acc, input bit sat, input int lat, input int hold);
      int cyc;
      load_ab(inst);
      run_model(inst, (inst == 0) ? 4 : 2, (inst == 0) ? 4 : 3, 4, acc, sat);
      if (inst == 0) chk1 = 1; else chk2 = 1;
      @(negedge clk);
      set_in(inst, 1, 1, acc, sat, 0);
      @(posedge clk);
      #1;
      set_in(inst, 0, 0, 0, 0, 0);
      check("a_ack_after_capture", o_aack(inst), 1);
      check("b_ack_after_capture", o_back(inst), 1);
      check("busy_after_capture", o_busy(inst), 1);
      cyc = 0;
      while (!o_cstb(inst) && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 1) check("a_ack_one_cycle", o_aack(inst), 0);
      end
      check("c_stb_latency", cyc, lat);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         check("c_stb_held", o_cstb(inst), 1);
      end
      @(negedge clk);
      set_in(inst, 0, 0, 0, 0, 1);
      @(posedge clk);
      #1;
      set_in(inst, 0, 0, 0, 0, 0);
      if (inst == 0) chk1 = 0; else chk2 = 0;
      check("c_stb_after_ack", o_cstb(inst), 0);
      check("busy_after_ack", o_busy(inst), 0);
   endtask

   // Per-cycle compare of C and ovf against the model while C is offered.
   always @(negedge clk) begin
      if (chk1 && cstb1) begin
         check("c_matrix_inst0", c1, exp_c1);
         check("ovf_inst0", ovf1, exp_ovf1);
      end
      if (chk2 && cstb2) begin
         check("c_matrix_inst1", c2, exp_c2);
         check("ovf_inst1", ovf2, exp_ovf2);
      end
   end

   task automatic set_identity();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            A[r][c] = (r == c) ? 1 : 0;
            B[r][c] = r * 4 + c + 1;
         end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 2; i++)
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) mc[i][r][c] = 0;
   endtask

   initial begin
      a1 = '0; b1 = '0; a2 = '0; b2 = '0;
      clear_model();
      #3 rst = 1'b0;
      #1;
      check("reset_c", c1, 0);
      check("reset_c_stb", cstb1, 0);
      check("reset_ack", {aack1, back1, aack2, back2}, 0);
      check("reset_busy_ovf", {busy1, ovf1, busy2, ovf2, cstb2}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // a_stb alone never captures
      @(negedge clk);
      set_in(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("lone_a_stb_no_ack", aack1, 0);
         check("lone_a_stb_not_busy", busy1, 0);
      end
      set_in(0, 0, 0, 0, 0, 0);

      // Identity
      set_identity();
      txn(0, 0, 0, 20, 5);
      check("identity_c00", c1[0:7], 8'd1);
      check("identity_c01", c1[8:15], 8'd2);
      check("identity_c33", c1[120:127], 8'd16);
      check("identity_ovf", ovf1, 0);

      // Accumulate
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) B[r][c] = 2;
      txn(0, 0, 0, 20, 0);
      check("acc_first_c00", c1[0:7], 8'd2);
      txn(0, 1, 0, 20, 0);
      check("acc_second_c00", c1[0:7], 8'd4);
      check("acc_second_c32", c1[112:119], 8'd4);

      // Overflow, saturate then wrap
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            A[r][c] = 100;
            B[r][c] = 100;
         end
      txn(0, 0, 1, 20, 0);
      check("sat_c00", c1[0:7], 8'd127);
      check("sat_ovf", ovf1, 1);
      txn(0, 0, 0, 20, 0);
      check("wrap_c00", c1[0:7], 8'd64);
      check("wrap_ovf", ovf1, 1);

      // Non-square signed shape on instance 1
      A[0][0] = -1; A[0][1] = 2;  A[0][2] = 3;
      A[1][0] = 4;  A[1][1] = -5; A[1][2] = 6;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 4; c++) B[r][c] = (c == r || c == 3) ? 1 : 0;
      txn(1, 0, 0, 16, 2);
      check("nsq_c00", c2[0:7], 8'hFF);
      check("nsq_c03", c2[24:31], 8'd4);
      check("nsq_c11", c2[40:47], 8'hFB);
      check("nsq_c13", c2[56:63], 8'd5);

      // Reset in the middle of CALC
      set_identity();
      load_ab(0);
      @(negedge clk);
      set_in(0, 1, 1, 0, 0, 0);
      @(posedge clk);
      #1;
      set_in(0, 0, 0, 0, 0, 0);
      repeat (5) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("midreset_c", c1, 0);
      check("midreset_flags", {cstb1, aack1, back1, busy1, ovf1}, 0);
      check("midreset_inst1_c", c2, 0);
      @(negedge clk);
      rst = 1'b1;
      clear_model();
      txn(0, 1, 0, 20, 1);
      check("rerun_c00", c1[0:7], 8'd1);
      check("rerun_c33", c1[120:127], 8'd16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
